// File: rtl/pix_fetch.sv
// Frame-buffer pixel prefetcher: fills a word FIFO from frame memory
// and serves one RGB332 byte per visible pixel clock.
module pix_fetch #(
  parameter int H_VISIBLE  = 1280,
  parameter int V_VISIBLE  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [10:0]       H_CNT,
  input  logic [10:0]       V_CNT,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_DATA,
  output logic [7:0]        PIX_DATA,
  output logic              UNDERFLOW
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int WORDS = H_VISIBLE * V_VISIBLE / 4;

  localparam logic [10:0]       H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0]       V_VIS = 11'(V_VISIBLE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WORDS - 1);
  localparam logic [PW:0]       FULL  = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [7:0]        pix_q, pix_d;
  logic              uf_q, uf_d;
  logic              fe_done_q, fe_done_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic        visible;
  logic        fe;
  logic        empty;
  logic        pop;
  logic        push;
  logic [31:0] head;

  assign visible = (H_CNT < H_VIS) && (V_CNT < V_VIS);
  // Frame end fires once per frame, rearmed when V leaves that line
  assign fe      = (V_CNT == V_VIS) && (H_CNT == 11'd0) && !fe_done_q;
  assign empty   = (cnt_q == '0);
  assign pop     = visible && (H_CNT[1:0] == 2'b11) && !empty;
  assign push    = (state_q == S_REQ) && MEM_ACK && !fe;
  assign head    = mem_q[rd_q];

  always_comb begin
    fe_done_d = (V_CNT == V_VIS) ? (fe_done_q | fe) : 1'b0;
    state_d   = state_q;
    addr_d    = addr_q;
    case (state_q)
      S_IDLE: begin
        if (fe) addr_d = '0;
        else if (cnt_q < FULL) state_d = S_REQ;
      end
      S_REQ: begin
        if (fe) begin
          state_d = MEM_ACK ? S_IDLE : S_FLUSH;
          addr_d  = MEM_ACK ? '0 : addr_q;
        end else if (MEM_ACK) begin
          state_d = S_IDLE;
          addr_d  = (addr_q == LAST) ? '0
                                     : addr_q + ADDR_W'(1);
        end
      end
      S_FLUSH: begin
        if (MEM_ACK) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (fe) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    pix_d = 8'h00;
    if (visible && !empty)
      pix_d = head[{H_CNT[1:0], 3'b000} +: 8];
    uf_d = uf_q;
    if (fe)                  uf_d = 1'b0;
    else if (visible && empty) uf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pix_q     <= 8'h00;
      uf_q      <= 1'b0;
      fe_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      pix_q     <= pix_d;
      uf_q      <= uf_d;
      fe_done_q <= fe_done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= MEM_DATA;
  end

  assign MEM_REQ   = (state_q == S_REQ) || (state_q == S_FLUSH);
  assign MEM_ADDR  = addr_q;
  assign PIX_DATA  = pix_q;
  assign UNDERFLOW = uf_q;

endmodule
